// File: rtl/falling_object_engine.sv
// -----------------------------------------------------------------------------
// falling_object_engine
//
// Purpose:
//   Runs NUM_OBJ independent falling objects on a ROWS x COLS grid. A shared
//   8-bit LFSR picks spawn columns, a spawn-gap counter spaces spawns apart,
//   and every object reaching the player row is resolved exactly once as
//   either a hit (same column as the player) or a landing (dodged). Hit and
//   landing counters drive a sticky game-over flag.
//
// Optional feature (compile-time macro FOBJ_SPEEDUP_EN):
//   Defined  : every 8 landings shorten the fall period by TICK_DIV>>3,
//              never below TICK_DIV>>2. A new period takes effect at the
//              counter wrap after the one on which it was computed.
//   Undefined: the fall period is fixed at TICK_DIV.
//
// Ports:
//   i_clk          system clock
//   i_clear_n      asynchronous active-low clear ("Clear")
//   i_run          1 = play, 0 = pause (the LFSR keeps running)
//   i_player_col   player column, sampled on each fall tick
//   o_obj_active   slot i is falling
//   o_obj_row      packed rows, slot i at [i*RW +: RW]
//   o_obj_col      packed columns, slot i at [i*CW +: CW]
//   o_hit_pulse    one-cycle pulse: at least one hit on this tick
//   o_land_pulse   one-cycle pulse: at least one landing on this tick
//   o_hit_count    hits taken, saturating at MAX_HITS
//   o_land_count   objects dodged, wraps 255 -> 0
//   o_game_over    sticky, set once o_hit_count reaches MAX_HITS
// -----------------------------------------------------------------------------
module falling_object_engine #(
    parameter int         NUM_OBJ   = 2,
    parameter int         ROWS      = 8,
    parameter int         COLS      = 8,
    parameter int         TICK_DIV  = 25000000,
    parameter int         SPAWN_GAP = 3,
    parameter int         MAX_HITS  = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    localparam int        RW        = $clog2(ROWS),
    localparam int        CW        = $clog2(COLS)
) (
    input  logic                  i_clk,
    input  logic                  i_clear_n,
    input  logic                  i_run,
    input  logic [CW-1:0]         i_player_col,
    output logic [NUM_OBJ-1:0]    o_obj_active,
    output logic [NUM_OBJ*RW-1:0] o_obj_row,
    output logic [NUM_OBJ*CW-1:0] o_obj_col,
    output logic                  o_hit_pulse,
    output logic                  o_land_pulse,
    output logic [3:0]            o_hit_count,
    output logic [7:0]            o_land_count,
    output logic                  o_game_over
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
    localparam int NW = $clog2(NUM_OBJ + 1);

    // ---------------------------------------------------------------------
    // Shared state
    // ---------------------------------------------------------------------
    logic [7:0]    r_lfsr;
    logic [TW-1:0] r_tick_cnt;
    logic [GW-1:0] r_gap;
    logic [3:0]    r_hit_count;
    logic [7:0]    r_land_count;
    logic          r_hit_pulse;
    logic          r_land_pulse;
    logic          r_game_over;

    logic [TW-1:0] w_period;
    logic          w_en;
    logic          w_tick;

    logic [NUM_OBJ-1:0] w_active;
    logic [NUM_OBJ-1:0] w_hit;
    logic [NUM_OBJ-1:0] w_land;
    logic [NUM_OBJ-1:0] w_spawn_sel;
    logic               w_any_idle;

    logic [NW-1:0] w_n_hit;
    logic [NW-1:0] w_n_land;
    logic [4:0]    w_hit_sum;
    logic [3:0]    w_hit_next;

    // Play advances only while running and not yet lost.
    assign w_en   = i_run && !r_game_over;
    assign w_tick = w_en && (r_tick_cnt == (w_period - TW'(1)));

    // ---------------------------------------------------------------------
    // Object slots
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_slot
            logic          r_act;
            logic [RW-1:0] r_row;
            logic [CW-1:0] r_col;
            logic          w_bottom;

            assign w_bottom   = (r_row == RW'(ROWS - 1));
            // Resolution uses the state at the start of the tick, so each
            // object is resolved exactly once as either hit or land.
            assign w_hit[gi]  = w_tick && r_act && w_bottom && (r_col == i_player_col);
            assign w_land[gi] = w_tick && r_act && w_bottom && (r_col != i_player_col);

            always_ff @(posedge i_clk or negedge i_clear_n) begin
                if (!i_clear_n) begin
                    r_act <= 1'b0;
                    r_row <= '0;
                    r_col <= '0;
                end else if (w_tick) begin
                    if (r_act) begin
                        if (w_bottom) begin
                            // Row/col are left as-is; consumers qualify with active.
                            r_act <= 1'b0;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end else if (w_spawn_sel[gi]) begin
                        r_act <= 1'b1;
                        r_row <= '0;
                        r_col <= r_lfsr[CW-1:0];
                    end
                end
            end

            assign w_active[gi]           = r_act;
            assign o_obj_row[gi*RW +: RW] = r_row;
            assign o_obj_col[gi*CW +: CW] = r_col;
        end
    endgenerate

    // Slots freed on this tick are still active here, so they cannot be
    // respawned until the following tick.
    assign w_any_idle = ~&w_active;

    // Lowest-index idle slot wins the spawn.
    always_comb begin
        logic found;
        found       = 1'b0;
        w_spawn_sel = '0;
        if (w_tick && (r_gap == '0)) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (!w_active[i] && !found) begin
                    w_spawn_sel[i] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
    end

    // Simultaneous resolutions all count.
    always_comb begin
        w_n_hit  = '0;
        w_n_land = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_n_hit  = w_n_hit  + NW'(w_hit[i]);
            w_n_land = w_n_land + NW'(w_land[i]);
        end
    end

    assign w_hit_sum  = {1'b0, r_hit_count} + 5'(w_n_hit);
    assign w_hit_next = (w_hit_sum >= 5'(MAX_HITS)) ? 4'(MAX_HITS) : w_hit_sum[3:0];

    // ---------------------------------------------------------------------
    // Fall period (fixed or speed-up)
    // ---------------------------------------------------------------------
`ifdef FOBJ_SPEEDUP_EN
    localparam int SPD_STEP  = TICK_DIV >> 3;
    localparam int SPD_FLOOR = TICK_DIV >> 2;

    logic [2:0]    r_spd_cnt;
    logic [TW-1:0] r_period;
    logic [TW-1:0] r_period_pend;
    logic [3:0]    w_spd_sum;

    // Bit 3 of the sum flags a wrap of the 3-bit landing counter.
    assign w_spd_sum = {1'b0, r_spd_cnt} + 4'(w_n_land);

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_spd_cnt     <= '0;
            r_period      <= TW'(TICK_DIV);
            r_period_pend <= TW'(TICK_DIV);
        end else if (w_tick) begin
            r_spd_cnt <= w_spd_sum[2:0];
            // Pending period is promoted at each wrap, so a reduction computed
            // now applies from the following wrap onwards.
            r_period  <= r_period_pend;
            if (w_spd_sum[3]) begin
                if (r_period_pend >= TW'(SPD_FLOOR + SPD_STEP)) begin
                    r_period_pend <= r_period_pend - TW'(SPD_STEP);
                end else begin
                    r_period_pend <= TW'(SPD_FLOOR);
                end
            end
        end
    end

    assign w_period = r_period;
`else
    assign w_period = TW'(TICK_DIV);
`endif

    // ---------------------------------------------------------------------
    // LFSR, tick counter, spawn gap, scoring
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_lfsr       <= LFSR_SEED;
            r_tick_cnt   <= '0;
            r_gap        <= '0;
            r_hit_count  <= '0;
            r_land_count <= '0;
            r_hit_pulse  <= 1'b0;
            r_land_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            // x^8+x^6+x^5+x^4+1, free-running regardless of run/game over.
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

            // w_hit/w_land are already gated by the tick.
            r_hit_pulse  <= |w_hit;
            r_land_pulse <= |w_land;

            if (w_en) begin
                r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + TW'(1));
            end

            if (w_tick) begin
                if (r_gap == '0) begin
                    if (w_any_idle) begin
                        r_gap <= GW'(SPAWN_GAP);
                    end
                end else begin
                    r_gap <= r_gap - GW'(1);
                end

                r_hit_count  <= w_hit_next;
                r_land_count <= r_land_count + 8'(w_n_land);
                if (w_hit_sum >= 5'(MAX_HITS)) begin
                    r_game_over <= 1'b1;
                end
            end
        end
    end

    assign o_obj_active = w_active;
    assign o_hit_pulse  = r_hit_pulse;
    assign o_land_pulse = r_land_pulse;
    assign o_hit_count  = r_hit_count;
    assign o_land_count = r_land_count;
    assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_falling_object_engine.sv
// -----------------------------------------------------------------------------
// tb_falling_object_engine
//
// Self-checking bench for falling_object_engine with NUM_OBJ=2, ROWS=8,
// COLS=8, TICK_DIV=4, SPAWN_GAP=3, MAX_HITS=3. A behavioural model tracks
// objects by the tick on which they spawned (row = ticks elapsed) and is
// compared against every DUT output each cycle; a vector table and a few
// hand-written sequences cover the specific timing corners.
// -----------------------------------------------------------------------------
module tb_falling_object_engine;

    localparam int NUM_OBJ   = 2;
    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int TICK_DIV  = 4;
    localparam int SPAWN_GAP = 3;
    localparam int MAX_HITS  = 3;
    localparam int RW        = 3;
    localparam int CW        = 3;

    logic                  clk     = 1'b0;
    logic                  clear_n = 1'b1;
    logic                  run     = 1'b0;
    logic [CW-1:0]         pcol    = '0;
    logic [NUM_OBJ-1:0]    obj_active;
    logic [NUM_OBJ*RW-1:0] obj_row;
    logic [NUM_OBJ*CW-1:0] obj_col;
    logic                  hit_pulse;
    logic                  land_pulse;
    logic [3:0]            hit_count;
    logic [7:0]            land_count;
    logic                  game_over;

    falling_object_engine #(
        .NUM_OBJ   (NUM_OBJ),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .TICK_DIV  (TICK_DIV),
        .SPAWN_GAP (SPAWN_GAP),
        .MAX_HITS  (MAX_HITS),
        .LFSR_SEED (8'hA5)
    ) dut (
        .i_clk        (clk),
        .i_clear_n    (clear_n),
        .i_run        (run),
        .i_player_col (pcol),
        .o_obj_active (obj_active),
        .o_obj_row    (obj_row),
        .o_obj_col    (obj_col),
        .o_hit_pulse  (hit_pulse),
        .o_land_pulse (land_pulse),
        .o_hit_count  (hit_count),
        .o_land_count (land_count),
        .o_game_over  (game_over)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;   // rising edges since the last Clear release

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    logic [7:0] m_lfsr;
    int         m_en_cycles, m_tickno, m_last_spawn, m_hits, m_lands;
    bit         m_go, m_hp, m_lp;
    bit         m_act [NUM_OBJ];
    int         m_spawn [NUM_OBJ];
    int         m_col [NUM_OBJ];
    int         m_idle_row [NUM_OBJ];

    function automatic void model_reset();
        m_lfsr       = 8'hA5;
        m_en_cycles  = 0;
        m_tickno     = 0;
        m_last_spawn = -1000;
        m_hits       = 0;
        m_lands      = 0;
        m_go         = 0;
        m_hp         = 0;
        m_lp         = 0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            m_act[i]      = 0;
            m_spawn[i]    = 0;
            m_col[i]      = 0;
            m_idle_row[i] = 0;
        end
    endfunction

    function automatic void model_step(input bit r, input int pc);
        logic [7:0] lf_now;
        bit         idle0 [NUM_OBJ];
        bit         done;
        int         nh, nl;
        lf_now = m_lfsr;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_hp   = 0;
        m_lp   = 0;
        if (!r || m_go) return;
        m_en_cycles++;
        if ((m_en_cycles % TICK_DIV) != 0) return;
        nh = 0;
        nl = 0;
        for (int i = 0; i < NUM_OBJ; i++) idle0[i] = !m_act[i];
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (m_act[i] && (m_tickno - m_spawn[i]) == ROWS - 1) begin
                if (m_col[i] == pc) nh++;
                else nl++;
                m_act[i]      = 0;
                m_idle_row[i] = ROWS - 1;
            end
        end
        m_tickno++;
        done = 0;
        if (m_tickno - m_last_spawn > SPAWN_GAP) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (idle0[i] && !done) begin
                    m_act[i]     = 1;
                    m_spawn[i]   = m_tickno;
                    m_col[i]     = int'(lf_now) % COLS;
                    m_last_spawn = m_tickno;
                    done         = 1;
                end
            end
        end
        m_hits  = (m_hits + nh > MAX_HITS) ? MAX_HITS : m_hits + nh;
        m_lands = (m_lands + nl) % 256;
        if (m_hits >= MAX_HITS) m_go = 1;
        m_hp = (nh > 0);
        m_lp = (nl > 0);
    endfunction

    function automatic int chase_col();
        for (int i = 0; i < NUM_OBJ; i++)
            if (m_act[i] && (m_tickno - m_spawn[i]) == ROWS - 1) return m_col[i];
        return int'(pcol);
    endfunction

    task automatic check_model();
        logic [31:0] e_act, e_row, e_col;
        e_act = '0;
        e_row = '0;
        e_col = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            e_act[i] = m_act[i];
            e_row[i*RW +: RW] = RW'(m_act[i] ? (m_tickno - m_spawn[i]) : m_idle_row[i]);
            e_col[i*CW +: CW] = CW'(m_col[i]);
        end
        chk("active",     32'(obj_active), e_act);
        chk("row",        32'(obj_row),    e_row);
        chk("col",        32'(obj_col),    e_col);
        chk("hit_pulse",  32'(hit_pulse),  32'(m_hp));
        chk("land_pulse", 32'(land_pulse), 32'(m_lp));
        chk("hit_count",  32'(hit_count),  32'(m_hits));
        chk("land_count", 32'(land_count), 32'(m_lands));
        chk("game_over",  32'(game_over),  32'(m_go));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (clear_n) begin
                model_step(run, int'(pcol));
                ecnt++;
            end
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("rst_active", 32'(obj_active), 32'd0);
        chk("rst_hits",   32'(hit_count),  32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_model();
        end
        clear_n = 1'b1;
        ecnt    = 0;
    endtask

    // ------------------------------------------------------------------
    // Vector table: test-plan timeline (slot0 spawns in column 2)
    // ------------------------------------------------------------------
    typedef struct {
        bit rst;
        int edge_n;
        int pc;
        int act;
        int row0;
        int col0;
        int lp;
        int hp;
        int lc;
        int hc;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int guard;

        vecs = '{
            // dodge: player in column 5
            '{1,  3, 5, 0, 0, -1, 0, 0, 0, 0},
            '{0,  4, 5, 1, 0,  2, 0, 0, 0, 0},
            '{0,  8, 5, 1, 1,  2, 0, 0, 0, 0},
            '{0, 20, 5, 3, 4,  2, 0, 0, 0, 0},
            '{0, 32, 5, 3, 7,  2, 0, 0, 0, 0},
            '{0, 36, 5, 2, 7,  2, 1, 0, 1, 0},
            '{0, 37, 5, 2, 7,  2, 0, 0, 1, 0},
            '{0, 40, 5, 3, 0, -1, 0, 0, 1, 0},
            // hit: player in column 2
            '{1, 35, 2, 3, 7,  2, 0, 0, 0, 0},
            '{0, 36, 2, 2, 7,  2, 0, 1, 0, 1},
            '{0, 37, 2, 2, 7,  2, 0, 0, 0, 1}
        };

        #1;
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].rst) do_reset();
            pcol  = CW'(vecs[v].pc);
            run   = 1'b1;
            guard = 0;
            while (ecnt < vecs[v].edge_n && guard < 1000) begin
                step(1);
                guard++;
            end
            chk("vec_active", 32'(obj_active), 32'(vecs[v].act));
            chk("vec_row0",   32'(obj_row[RW-1:0]), 32'(vecs[v].row0));
            if (vecs[v].col0 >= 0) chk("vec_col0", 32'(obj_col[CW-1:0]), 32'(vecs[v].col0));
            chk("vec_land_pulse", 32'(land_pulse), 32'(vecs[v].lp));
            chk("vec_hit_pulse",  32'(hit_pulse),  32'(vecs[v].hp));
            chk("vec_land_count", 32'(land_count), 32'(vecs[v].lc));
            chk("vec_hit_count",  32'(hit_count),  32'(vecs[v].hc));
        end

        // --------------------------------------------------------------
        // Game over: chase falling objects until three hits
        // --------------------------------------------------------------
        do_reset();
        run   = 1'b1;
        guard = 0;
        while (!m_go && guard < 400) begin
            pcol = CW'(chase_col());
            step(1);
            guard++;
        end
        chk("go_reached",   32'(game_over), 32'd1);
        chk("go_hit_count", 32'(hit_count), 32'(MAX_HITS));
        for (int k = 0; k < 200; k++) begin
            pcol = CW'($urandom_range(0, COLS - 1));
            step(1);
        end
        chk("go_frozen_hits", 32'(hit_count), 32'(MAX_HITS));
        chk("go_sticky",      32'(game_over), 32'd1);
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        chk("clr_active",  32'(obj_active), 32'd0);
        chk("clr_row",     32'(obj_row),    32'd0);
        chk("clr_col",     32'(obj_col),    32'd0);
        chk("clr_hits",    32'(hit_count),  32'd0);
        chk("clr_go",      32'(game_over),  32'd0);

        // --------------------------------------------------------------
        // Pause at tick counter 2
        // --------------------------------------------------------------
        do_reset();
        run  = 1'b1;
        pcol = 3'd5;
        step(6);
        chk("pause_row_before", 32'(obj_row[RW-1:0]), 32'd0);
        run = 1'b0;
        step(50);
        chk("pause_row_held", 32'(obj_row[RW-1:0]), 32'd0);
        run = 1'b1;
        step(1);
        chk("resume_no_tick", 32'(obj_row[RW-1:0]), 32'd0);
        step(1);
        chk("resume_tick", 32'(obj_row[RW-1:0]), 32'd1);

        // --------------------------------------------------------------
        // Randomized play against the model
        // --------------------------------------------------------------
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset();
            for (int k = 0; k < 600; k++) begin
                run  = ($urandom_range(0, 7) != 0);
                pcol = CW'($urandom_range(0, COLS - 1));
                step(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/falling_object_engine.md
# falling_object_engine

Parametrised successor to the two-object falling-item logic of the dodge game. Manages NUM_OBJ independent falling objects on a ROWS x COLS grid from a single clock, with a shared pseudo-random column generator, spawn spacing, exactly-once collision/landing resolution against the player column, and hit/score counters with game-over. Sits between the player-control block and the LED-matrix/7-segment display multiplexers.

## Interface
- NUM_OBJ, 2: number of object slots (1-8)
- ROWS, 8: grid rows; row ROWS-1 is the player row
- COLS, 8: grid columns, power of two
- TICK_DIV, 25000000: CLK cycles per fall step
- SPAWN_GAP, 3: idle ticks forced after each spawn
- MAX_HITS, 8: hit count that asserts game_over (1-15)
- LFSR_SEED, 8'hA5: LFSR reset value, nonzero
- CLK  in  1  system clock
- Clear  in  1  asynchronous active-low reset
- run  in  1  1 = play; 0 = pause (freezes all state except LFSR)
- player_col  in  CW=$clog2(COLS)  player column, sampled at each tick
- obj_active  out  NUM_OBJ  slot i is falling
- obj_row  out  NUM_OBJ*RW (RW=$clog2(ROWS))  packed rows, slot i at [i*RW +: RW]
- obj_col  out  NUM_OBJ*CW  packed columns
- hit_pulse  out  1  one-CLK pulse, at least one object hit the player this tick
- land_pulse  out  1  one-CLK pulse, at least one object landed unhit this tick
- hit_count  out  4  hits taken, saturates at MAX_HITS
- land_count  out  8  objects dodged (score), wraps 255->0
- game_over  out  1  sticky, set when hit_count reaches MAX_HITS

## Operation
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every CLK regardless of run/game_over; spawn column = lfsr[CW-1:0] on the spawn edge.
- Tick counter: counts 0..period-1 while run=1 and game_over=0; tick asserted on the edge where counter==period-1; counter wraps to 0.
- Per slot state: IDLE or FALL. On tick, for each FALL slot (state at start of tick):
  - row<ROWS-1: row+1.
  - row==ROWS-1 and col==player_col: hit, slot -> IDLE.
  - row==ROWS-1 otherwise: land, slot -> IDLE.
- Spawn, on tick: if gap==0 and some slot was IDLE at start of tick, lowest-index such slot -> FALL, row 0, col from LFSR; gap<=SPAWN_GAP. Else if gap!=0, gap-1. Slots freed this tick are not eligible until the next tick.
- Counters: simultaneous resolutions all count; hit_count += number of hits (saturate MAX_HITS); land_count += number of landings (mod 256).
- game_over set on the edge hit_count becomes >= MAX_HITS; then tick stops, all slots hold, pulses stay 0. Cleared only by Clear.
- IDLE slots hold their last row/col; consumers must qualify with obj_active.

## Timing
- Clear low: all outputs 0, obj_row/obj_col 0, tick counter 0, gap 0, lfsr=LFSR_SEED, period=TICK_DIV, immediately and asynchronously; mid-fall objects vanish.
- First tick: TICK_DIV-th rising edge after Clear release with run=1.
- All outputs registered; state, counters, pulses update on the same tick edge.
- A slot spawned at tick k shows rows 0..ROWS-1 on ticks k..k+ROWS-1, resolves at tick k+ROWS.
- run low mid-period: counter holds, resumes from held value.
- Spawns at most every SPAWN_GAP+1 ticks.

## Configuration
- FOBJ_SPEEDUP_EN defined: a 3-bit land counter tracks landings; each wrap past 7 reduces period by TICK_DIV>>3, floor TICK_DIV>>2; new period applies from the next counter wrap. Hits do not count. Clear restores TICK_DIV.
- Undefined: period fixed at TICK_DIV; no speedup logic.

## Test plan
Bench: NUM_OBJ=2, ROWS=8, COLS=8, TICK_DIV=4, SPAWN_GAP=3, MAX_HITS=3, macro off unless stated.
- Release Clear, run=1 -> edge 4: obj_active=01, slot0 row 0, col = lfsr[2:0] at that edge; edge 20: slot1 spawns (tick 5).
- player_col != slot0 col -> tick 9 (edge 36): land_pulse=1 for one CLK, land_count=1, obj_active=10; slot0 respawns tick 10.
- player_col = slot0 col at tick 9 -> hit_pulse=1, hit_count=1, land_count=0.
- Three hits -> game_over=1 on third hit edge; obj_row/hit_count frozen 200 cycles; Clear low -> all 0.
- run=0 for 50 cycles at tick counter 2 -> no row change; run=1 -> next tick after 1 more cycle.
- FOBJ_SPEEDUP_EN, TICK_DIV=64, 8 landings -> tick spacing 56 cycles; after 48 landings spacing stays 16.
